// File: rtl/fetch_queue.sv
// Fetch stage: PC register, combinational instruction-ROM access and a DEPTH-entry
// prefetch FIFO feeding decode over a valid/ready handshake.
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP_WORD = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [XLEN-1:0]            imem_rdata,
    input  logic                       pred_taken,
    input  logic [XLEN-1:0]            pred_target,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    input  logic                       hlt,
    input  logic                       dec_ready,
    output logic                       out_valid,
    output logic [XLEN-1:0]            instr_out,
    output logic [XLEN-1:0]            pc_out,
    output logic [XLEN-1:0]            pc4_out,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       halted
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] pc;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            halted_q;

    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];

    logic full;
    logic head_valid;
    logic deq;
    logic enq;

    always_comb begin
        full       = (count == CW'(DEPTH));
        // A redirect kills the head combinationally so decode never sees a stale entry.
        head_valid = (count != '0) & ~redirect_valid;
        deq        = head_valid & dec_ready;
        enq        = ~halted_q & ~hlt & ~redirect_valid & (~full | deq);
    end

    always_comb begin
        imem_addr = pc;
        out_valid = head_valid;
        occupancy = count;
        halted    = halted_q;
        if (head_valid) begin
            instr_out = instr_mem[rd_ptr];
            pc_out    = pc_mem[rd_ptr];
            pc4_out   = pc_mem[rd_ptr] + XLEN'(4);
        end else begin
            instr_out = NOP_WORD;
            pc_out    = '0;
            pc4_out   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            halted_q <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            halted_q <= 1'b0;
        end else begin
            if (enq) begin
                pc     <= pred_taken ? pred_target : pc + XLEN'(4);
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(enq) - CW'(deq);
            if (hlt) begin
                halted_q <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]    <= pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a queue-based reference model.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        hlt;
    logic        dec_ready;
    logic        out_valid;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc4_out;
    logic [2:0]  occupancy;
    logic        halted;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a >> 2) ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata = rom(imem_addr);

    fetch_queue #(
        .XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .NOP_WORD(32'h0)
    ) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .hlt(hlt),
        .dec_ready(dec_ready), .out_valid(out_valid), .instr_out(instr_out),
        .pc_out(pc_out), .pc4_out(pc4_out), .occupancy(occupancy), .halted(halted)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: FIFO of {instr, pc} plus architectural pc and halt flag.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc = 32'h0;
    bit          m_halted = 1'b0;
    bit          m_deq;
    bit          m_enq;
    bit          m_valid;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            mq.delete();
            m_pc = 32'h0;
            m_halted = 1'b0;
        end else if (redirect_valid) begin
            mq.delete();
            m_pc = redirect_pc;
            m_halted = 1'b0;
        end else begin
            m_deq = (mq.size() != 0) && dec_ready;
            m_enq = !m_halted && !hlt && (mq.size() < 4 || m_deq);
            if (m_deq) void'(mq.pop_front());
            if (m_enq) begin
                mq.push_back('{rom(m_pc), m_pc});
                m_pc = pred_taken ? pred_target : m_pc + 32'd4;
            end
            if (hlt) m_halted = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset) begin
            m_valid = (mq.size() != 0) && !redirect_valid;
            check("m.out_valid", out_valid, m_valid);
            check("m.instr_out", instr_out, m_valid ? mq[0].instr : 32'h0);
            check("m.pc_out", pc_out, m_valid ? mq[0].pc : 32'h0);
            check("m.pc4_out", pc4_out, m_valid ? mq[0].pc + 32'd4 : 32'h0);
            check("m.occupancy", occupancy, mq.size());
            check("m.halted", halted, m_halted);
            check("m.imem_addr", imem_addr, m_pc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; pred_taken = 1'b0; pred_target = '0; redirect_valid = 1'b0;
        redirect_pc = '0; hlt = 1'b0; dec_ready = 1'b1;
        #12;
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.instr_out", instr_out, 32'h0);
        check("rst.imem_addr", imem_addr, 32'h0);
        check("rst.occupancy", occupancy, 32'd0);
        @(negedge clk) reset = 1'b1;

        // Sequential fetch from reset.
        tick();
        check("seq.valid", out_valid, 1'b1);
        check("seq.pc0", pc_out, 32'h0);
        check("seq.instr0", instr_out, 32'hC0DE_0000);
        tick(); check("seq.pc1", pc_out, 32'h4);
        tick(); check("seq.pc2", pc_out, 32'h8);
        check("seq.pc4", pc4_out, 32'hC);

        // Stall until full, then streaming while full.
        dec_ready = 1'b0;
        repeat (10) tick();
        check("stall.occ", occupancy, 32'd4);
        check("stall.pc_out", pc_out, 32'h8);
        check("stall.addr", imem_addr, 32'h18);
        dec_ready = 1'b1;
        tick(); check("full.occ", occupancy, 32'd4); check("full.pc_out", pc_out, 32'hC);
        tick(); check("full.occ2", occupancy, 32'd4); check("full.pc_out2", pc_out, 32'h10);

        // Predicted-taken branch at pc 8.
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        #1 check("redir.kill", out_valid, 1'b0);
        tick(); redirect_valid = 1'b0;
        check("redir.occ", occupancy, 32'd0);
        tick(); check("pred.pc0", pc_out, 32'h0);
        tick(); check("pred.pc1", pc_out, 32'h4);
        check("pred.addr", imem_addr, 32'h8);
        pred_taken = 1'b1; pred_target = 32'h40;
        tick(); pred_taken = 1'b0;
        check("pred.pc2", pc_out, 32'h8);
        check("pred.addr2", imem_addr, 32'h40);
        tick(); check("pred.pc3", pc_out, 32'h40);
        tick(); check("pred.pc4", pc_out, 32'h44);

        // Redirect with three entries queued.
        dec_ready = 1'b0;
        tick(); tick();
        check("r3.occ", occupancy, 32'd3);
        redirect_valid = 1'b1; redirect_pc = 32'h100; dec_ready = 1'b1;
        #1 check("r3.kill", out_valid, 1'b0);
        check("r3.nop", instr_out, 32'h0);
        tick(); redirect_valid = 1'b0;
        check("r3.occ0", occupancy, 32'd0);
        check("r3.novalid", out_valid, 1'b0);
        tick();
        check("r3.valid", out_valid, 1'b1);
        check("r3.pc", pc_out, 32'h100);

        // Halt with two entries queued.
        redirect_valid = 1'b1; redirect_pc = 32'h8; dec_ready = 1'b0;
        tick(); redirect_valid = 1'b0;
        tick(); tick();
        check("h.occ2", occupancy, 32'd2);
        hlt = 1'b1;
        tick(); hlt = 1'b0; dec_ready = 1'b1;
        check("h.halted", halted, 1'b1);
        check("h.occ", occupancy, 32'd2);
        tick(); check("h.drain", pc_out, 32'hC);
        tick();
        check("h.empty", out_valid, 1'b0);
        check("h.nop", instr_out, 32'h0);
        check("h.addr", imem_addr, 32'h10);
        tick(); check("h.stuck", imem_addr, 32'h10);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick(); redirect_valid = 1'b0;
        check("h.cleared", halted, 1'b0);

        // Asynchronous reset between edges.
        tick(); tick();
        #3 reset = 1'b0;
        #1;
        check("arst.valid", out_valid, 1'b0);
        check("arst.occ", occupancy, 32'd0);
        check("arst.addr", imem_addr, 32'h0);
        check("arst.halted", halted, 1'b0);
        #1 reset = 1'b1;

        // Random traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            tick();
            dec_ready      = ($urandom_range(0, 9) < 7);
            pred_taken     = ($urandom_range(0, 4) == 0);
            pred_target    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8
                                                         : ($urandom() & 32'hFFFF_FFFC);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4
                                                         : ($urandom() & 32'hFFFF_FFFC);
            hlt            = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #1 reset = 1'b0;
                #1 reset = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
